// File: rtl/hack_mem_pkg.sv
// Shared types and constants for the Hack unified-memory arbiter.
package hack_mem_pkg;

  // Default widths: word address of addressM and the Hack data word.
  localparam int unsigned HACK_AW = 15;
  localparam int unsigned HACK_DW = 16;

  // Width of the fetch starvation counter (STARVE_MAX fits in 1..15).
  localparam int unsigned STARVE_W = 4;

  // ARB: normal fixed-priority arbitration; LOCKED: data port owns the RAM.
  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Which port a pending read belongs to.
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

endpackage

// File: rtl/hack_starve_counter.sv
// Saturating count of consecutive cycles in which fetch was denied.
// Freeze takes priority over clear, and clear over increment.
module hack_starve_counter
  import hack_mem_pkg::*;
#(
  parameter int unsigned MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  input  logic frz_i,
  output logic sat_o
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  // Next count: hold, clear, or step up until the threshold is reached.
  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (!frz_i) begin
      if (clr_i) begin
        cnt_d = '0;
      end else if (inc_i && (cnt_q < MAX_C)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Count register.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == MAX_C);

endmodule

// File: rtl/hack_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the
// data (M) port. Data has fixed priority; fetch is guaranteed a grant after
// STARVE_MAX consecutive denials. A locked data read keeps ownership for the
// following write of a read-modify-write sequence.
module hack_mem_arbiter
  import hack_mem_pkg::*;
#(
  parameter int unsigned AW         = HACK_AW,
  parameter int unsigned DW         = HACK_DW,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  // Fetch port (read only)
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [DW-1:0] fetch_rdata,
  // Data port
  input  logic          data_req,
  input  logic          data_we,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  input  logic          data_lock,
  output logic          data_gnt,
  output logic          data_rvalid,
  output logic [DW-1:0] data_rdata,
  // RAM macro
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t    state_q, state_d;
  logic          run_q;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_owner_q, rd_owner_d;
  logic [DW-1:0] fetch_rdata_q, data_rdata_q;
  logic          starve_sat;

  // Fetch starvation guard: counts only while arbitrating, frozen when locked.
  hack_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (fetch_req && !fetch_gnt),
    .clr_i (fetch_gnt || !fetch_req),
    .frz_i (state_q == LOCKED),
    .sat_o (starve_sat)
  );

  // Grant selection and lock state transitions. run_q keeps every grant low
  // until the first rising edge after reset is released.
  always_comb begin
    fetch_gnt = 1'b0;
    data_gnt  = 1'b0;
    state_d   = state_q;
    if (run_q) begin
      case (state_q)
        ARB: begin
          if (fetch_req && starve_sat) begin
            fetch_gnt = 1'b1;
          end else if (data_req) begin
            data_gnt = 1'b1;
            if (data_lock) state_d = LOCKED;
          end else if (fetch_req) begin
            fetch_gnt = 1'b1;
          end
        end
        LOCKED: begin
          if (data_req) begin
            data_gnt = 1'b1;
            if (!data_lock) state_d = ARB;
          end else begin
            state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  // RAM command follows whichever port won this cycle.
  always_comb begin
    mem_en     = fetch_gnt || data_gnt;
    mem_we     = data_gnt && data_we;
    mem_addr   = data_gnt ? data_addr : fetch_addr;
    mem_wdata  = data_wdata;
    rd_pend_d  = fetch_gnt || (data_gnt && !data_we);
    rd_owner_d = data_gnt ? OWN_DATA : OWN_FETCH;
  end

  // Read return: the owner sees the RAM output live; the other port holds
  // the last word it was given.
  assign fetch_rvalid = rd_pend_q && (rd_owner_q == OWN_FETCH);
  assign data_rvalid  = rd_pend_q && (rd_owner_q == OWN_DATA);
  assign fetch_rdata  = fetch_rvalid ? mem_rdata : fetch_rdata_q;
  assign data_rdata   = data_rvalid  ? mem_rdata : data_rdata_q;

  // Arbiter state, pending-read tracking and held read data.
  // NOTE: the held read-data words are plain registers, not storage arrays, so they take the reset and read back as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ARB;
      run_q         <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_owner_q    <= OWN_FETCH;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      if (fetch_rvalid) fetch_rdata_q <= mem_rdata;
      if (data_rvalid)  data_rdata_q  <= mem_rdata;
    end
  end

endmodule
